// File: rtl/soc_sram_wb.sv
// rtl/soc_sram_wb.sv - Wishbone B3 slave terminating on a single-port SRAM with 1-cycle read latency
// Classic cycles plus incrementing bursts (linear/wrap4/wrap8/wrap16) at one beat per cycle.
module soc_sram_wb #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  ADDR_WIDTH     = 32,
    parameter int  MEM_ADDR_WIDTH = 10,
    localparam int SEL_WIDTH      = DATA_WIDTH / 8,
    localparam int BOFS           = $clog2(SEL_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic [SEL_WIDTH-1:0]      wb_sel_i,
    input  logic                      wb_we_i,
    input  logic [2:0]                wb_cti_i,
    input  logic [1:0]                wb_bte_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    output logic                      sram_ce_o,
    output logic                      sram_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [SEL_WIDTH-1:0]      sram_be_o,
    output logic [DATA_WIDTH-1:0]     sram_wdat_o,
    input  logic [DATA_WIDTH-1:0]     sram_rdat_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_SINGLE, ST_BURST} state_e;

    state_e                    state_q, state_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [MEM_ADDR_WIDTH-1:0] cur_adr_q, cur_adr_d;
    logic [1:0]                bte_q, bte_d;

    logic                      req;
    logic [MEM_ADDR_WIDTH-1:0] word_adr;
    logic [MEM_ADDR_WIDTH-1:0] nxt_adr;
    logic                      cti_reserved;
    logic                      cti_end;
    logic                      burst_hold;
    logic                      unused_adr_bits;

    function automatic logic [MEM_ADDR_WIDTH-1:0] next_adr(
        input logic [MEM_ADDR_WIDTH-1:0] a,
        input logic [1:0]                bte
    );
        logic [MEM_ADDR_WIDTH-1:0] inc;
        logic [MEM_ADDR_WIDTH-1:0] mask;
        inc = a + MEM_ADDR_WIDTH'(1);
        case (bte)
            2'b00:   mask = '1;
            2'b01:   mask = MEM_ADDR_WIDTH'(3);
            2'b10:   mask = MEM_ADDR_WIDTH'(7);
            default: mask = MEM_ADDR_WIDTH'(15);
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    assign req             = wb_cyc_i & wb_stb_i;
    assign word_adr        = wb_adr_i[BOFS +: MEM_ADDR_WIDTH];
    assign nxt_adr         = next_adr(cur_adr_q, bte_q);
    assign cti_reserved    = (wb_cti_i >= 3'b011) && (wb_cti_i <= 3'b110);
    assign cti_end         = (wb_cti_i == 3'b111);
    // A burst continues only while the master keeps presenting the beat we predicted.
    assign burst_hold      = req && (word_adr == cur_adr_q) && (wb_bte_i == bte_q);
    assign unused_adr_bits = ^wb_adr_i;

    assign wb_ack_o    = ack_q & req;
    assign wb_err_o    = err_q & req;
    assign wb_rty_o    = 1'b0;
    assign wb_dat_o    = sram_rdat_i;
    assign sram_be_o   = wb_sel_i;
    assign sram_wdat_o = wb_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            cur_adr_q <= '0;
            bte_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            cur_adr_q <= cur_adr_d;
            bte_q     <= bte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        err_d     = err_q;
        cur_adr_d = cur_adr_q;
        bte_d     = bte_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cur_adr_d = word_adr;
                    bte_d     = wb_bte_i;
                    if (cti_reserved) begin
                        err_d   = 1'b1;
                        state_d = ST_SINGLE;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = (wb_cti_i == 3'b010) ? ST_BURST : ST_SINGLE;
                    end
                end
            end
            ST_SINGLE: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            ST_BURST: begin
                if (!burst_hold || cti_end) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cur_adr_d = nxt_adr;
                end
            end
            default: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reads are issued one cycle ahead of their ack; writes land in the ack cycle itself.
    always_comb begin
        sram_ce_o   = 1'b0;
        sram_we_o   = 1'b0;
        sram_addr_o = cur_adr_q;
        case (state_q)
            ST_IDLE: begin
                if (req && !cti_reserved && !wb_we_i) begin
                    sram_ce_o   = 1'b1;
                    sram_addr_o = word_adr;
                end
            end
            ST_SINGLE: begin
                if (wb_ack_o && wb_we_i) begin
                    sram_ce_o = 1'b1;
                    sram_we_o = 1'b1;
                end
            end
            ST_BURST: begin
                if (burst_hold) begin
                    if (wb_we_i) begin
                        sram_ce_o = 1'b1;
                        sram_we_o = 1'b1;
                    end else if (!cti_end) begin
                        sram_ce_o   = 1'b1;
                        sram_addr_o = nxt_adr;
                    end
                end
            end
            default: begin
                sram_ce_o = 1'b0;
            end
        endcase
        if (!rst_ni) begin
            sram_ce_o = 1'b0;
            sram_we_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_soc_sram_wb.sv
// tb/tb_soc_sram_wb.sv - scoreboard bench for soc_sram_wb with an SRAM model and a reference memory
module tb_soc_sram_wb;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int MAW   = 10;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << MAW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [AW-1:0]  adr;
    logic [DW-1:0]  dat_w;
    logic           cyc, stb, we;
    logic [SW-1:0]  sel;
    logic [2:0]     cti;
    logic [1:0]     bte;
    logic [DW-1:0]  dat_r;
    logic           ack, err, rty;
    logic           sram_ce, sram_we;
    logic [MAW-1:0] sram_addr;
    logic [SW-1:0]  sram_be;
    logic [DW-1:0]  sram_wdat;
    logic [DW-1:0]  sram_rdat;

    always #5 clk = ~clk;

    soc_sram_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_r), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
        .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_be_o(sram_be), .sram_wdat_o(sram_wdat), .sram_rdat_i(sram_rdat)
    );

    logic [DW-1:0] init_img [DEPTH];
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    bit            mem_init_done = 1'b0;
    int            wr_count = 0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_img[i];
            mem_init_done <= 1'b1;
        end else if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < SW; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdat[8*b +: 8];
                wr_count <= wr_count + 1;
            end else begin
                sram_rdat <= sram_mem[sram_addr];
            end
        end
    end

    typedef struct {
        bit            is_err;
        bit            is_read;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [AW-1:0] hi_bits = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (ack || err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {err, ack}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("resp_kind", {err, ack}, e.is_err ? 2'b10 : 2'b01);
                if (e.is_read && !e.is_err) check("rdata", dat_r, e.data);
            end
        end
    end

    function automatic logic [AW-1:0] mk_adr(input int word);
        return (hi_bits & ~AW'(4 * DEPTH - 1)) | (AW'(word) << 2);
    endfunction

    // Word address of beat i, written as plain modular arithmetic over the wrap block.
    function automatic int beat_addr(input int start, input int b, input int i);
        int n;
        if (b == 0) return (start + i) % DEPTH;
        n = 2 << b;
        return (start / n) * n + ((start % n) + i) % n;
    endfunction

    task automatic apply_write(input int word, input logic [SW-1:0] s, input logic [DW-1:0] d);
        for (int b = 0; b < SW; b++)
            if (s[b]) ref_mem[word][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic classic(input bit w, input int word, input logic [SW-1:0] s,
                           input logic [DW-1:0] d, input logic [2:0] c);
        exp_t e;
        bit   rsv;
        bit   any_ce;
        int   n;
        rsv       = (c >= 3'b011) && (c <= 3'b110);
        any_ce    = 1'b0;
        n         = 0;
        e.is_err  = rsv;
        e.is_read = !w;
        e.data    = ref_mem[word];
        if (w && !rsv) apply_write(word, s, d);
        exp_q.push_back(e);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_w = d; cti = c;
        bte = 2'($urandom_range(0, 3));
        adr = mk_adr(word);
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (sram_ce) any_ce = 1'b1;
            if (n == 1) begin
                check("c_strobe_ce", sram_ce, !w && !rsv);
                if (!w && !rsv) check("c_read_addr", {sram_we, sram_addr}, {1'b0, MAW'(word)});
            end
            if (ack || err) break;
            @(posedge clk); #1;
        end
        check("c_latency", n, 2);
        if (w && !rsv)
            check("c_write_strobe", {sram_ce, sram_we, sram_addr, sram_be, sram_wdat},
                  {1'b1, 1'b1, MAW'(word), s, d});
        if (rsv) check("c_rsv_no_ce", any_ce, 1'b0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("c_resp_after", {err, ack}, 2'b00);
    endtask

    // mode 0: complete burst; 1: drop strobe after abort_after acks; 2: reset after abort_after acks
    task automatic burst(input bit w, input int start, input int b, input int nb,
                         input int abort_after, input int mode);
        int            adrs[$];
        logic [DW-1:0] dats[$];
        logic [SW-1:0] s;
        exp_t          e;
        int            target, idx, acked, n, first, last, gaps, wr0;
        s      = w ? SW'($urandom_range(1, (1 << SW) - 1)) : '1;
        target = (mode == 0) ? nb : abort_after;
        idx = 0; acked = 0; n = 0; first = 0; last = 0; gaps = 0;
        for (int i = 0; i < nb; i++) begin
            adrs.push_back(beat_addr(start, b, i));
            dats.push_back($urandom);
        end
        for (int i = 0; i < target; i++) begin
            e.is_err  = 1'b0;
            e.is_read = !w;
            e.data    = ref_mem[adrs[i]];
            if (w) apply_write(adrs[i], s, dats[i]);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        wr0 = wr_count;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; bte = 2'(b);
        adr = mk_adr(adrs[0]); dat_w = dats[0]; cti = (nb == 1) ? 3'b111 : 3'b010;
        while (acked < target && n < 64) begin
            @(negedge clk);
            n++;
            if (ack) begin
                acked++;
                if (acked == 1) first = n;
                else if (n != last + 1) gaps++;
                last = n;
                if (w)
                    check("b_write_strobe", {sram_ce, sram_we, sram_addr, sram_be, sram_wdat},
                          {1'b1, 1'b1, MAW'(adrs[idx]), s, dats[idx]});
                else if (idx == nb - 1)
                    check("b_last_no_prefetch", sram_ce, 1'b0);
                else
                    check("b_prefetch", {sram_ce, sram_we, sram_addr}, {1'b1, 1'b0, MAW'(adrs[idx+1])});
                idx++;
            end
            @(posedge clk); #1;
            if (idx < nb) begin
                adr   = mk_adr(adrs[idx]);
                dat_w = dats[idx];
                cti   = (idx == nb - 1) ? 3'b111 : 3'b010;
            end
        end
        check("b_acks", acked, target);
        check("b_first_latency", first, 2);
        check("b_gaps", gaps, 0);
        if (mode == 1) begin
            stb = 1'b0;
            @(negedge clk);
            check("drop_ack", ack, 1'b0);
        end else if (mode == 2) begin
            #2 rst_n = 1'b0;
            #1 check("rst_mid_outputs", {ack, err, sram_ce, sram_we}, 4'b0000);
            cyc = 1'b0; stb = 1'b0;
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b1;
        end else begin
            cyc = 1'b0; stb = 1'b0;
            @(negedge clk);
            check("b_ack_after", ack, 1'b0);
            check("b_write_count", wr_count - wr0, w ? nb : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            diffs;
        int            k;
        logic [2:0]    c;
        logic [DW-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            init_img[i] = v;
        end
        init_img[5] = 32'hA5A5_0005;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_img[i];

        rst_n = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = '1; cti = 3'b000; bte = 2'b00;
        adr = '0; dat_w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {ack, err, rty, sram_ce, sram_we}, 5'b00000);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        classic(1'b0, 5, '1, '0, 3'b000);
        classic(1'b1, 8, 4'b0100, 32'h00AB_0000, 3'b000);
        classic(1'b0, 8, '1, '0, 3'b000);
        burst(1'b0, 6, 1, 4, 0, 0);
        burst(1'b1, DEPTH - 1, 0, 3, 0, 0);
        classic(1'b0, DEPTH - 1, '1, '0, 3'b000);
        classic(1'b0, 0, '1, '0, 3'b000);
        classic(1'b0, 1, '1, '0, 3'b000);
        burst(1'b0, 100, 0, 5, 2, 1);
        classic(1'b0, 102, '1, '0, 3'b111);
        classic(1'b0, 9, '1, '0, 3'b101);
        burst(1'b0, 200, 2, 6, 2, 2);
        classic(1'b0, 300, '1, '0, 3'b000);

        for (int t = 0; t < 60; t++) begin
            hi_bits = $urandom;
            k = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       c = 3'b000;
                1:       c = 3'b001;
                default: c = 3'b111;
            endcase
            if (k < 3)
                classic(1'b0, $urandom_range(0, DEPTH - 1), '1, '0, c);
            else if (k < 5)
                classic(1'b1, $urandom_range(0, DEPTH - 1), SW'($urandom_range(0, 15)), $urandom, c);
            else if (k == 5)
                classic(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                        SW'($urandom_range(0, 15)), $urandom, 3'($urandom_range(3, 6)));
            else
                burst(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                      $urandom_range(0, 3), $urandom_range(2, 10), 0, 0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (sram_mem[i] !== ref_mem[i]) diffs++;
        check("final_memory_diffs", diffs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
